vwrite_pp: RTL and testbench
============================

Name: vwrite_pp

Overview:
- Parametrised successor to the Versat VWrite unit, for the Versat I/O datapath.
- Accepts a valid/ready word stream from the accelerator datapath and buffers it in one bank, or two ping-pong banks, of internal 2-port RAM.
- Drains the buffered words to the external databus as multi-frame, length-split, 4 KB-safe bursts.
- Differs from the previous generation: input handshake back-pressure, multi-frame transfers, bus error flagging, and fill/drain overlap in ping-pong mode.

Parameters:
- DATA_W, 32, databus and stream word width; multiple of 8.
- IO_ADDR_W, 32, external byte-address width.
- MEM_ADDR_W, 10, per-bank word-address width; bank depth is 2^MEM_ADDR_W.
- SIZE_W, 11, width of the frame-size field; must be ≥ MEM_ADDR_W+1.
- FRAMES_W, 8, width of the frame-count field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  single-cycle start pulse; latches all configuration inputs.
- done  out  1  high when idle and the last frame is fully written; cleared by run.
- err  out  1  sticky flag: databus_last did not coincide with the final beat; cleared by run.
- in_valid  in  1  input stream word valid.
- in_ready  out  1  unit can accept an input word.
- in_data  in  DATA_W  input stream word.
- databus_valid  out  1  write beat valid.
- databus_ready  in  1  slave accepts the beat.
- databus_addr  out  IO_ADDR_W  burst start byte address; held for the whole burst.
- databus_wdata  out  DATA_W  write data.
- databus_wstrb  out  DATA_W/8  all ones.
- databus_len  out  8  beats-1 of the current burst; held for the whole burst.
- databus_last  in  1  slave marks the final beat.
- ext_addr  in  IO_ADDR_W  base byte address of frame 0; DATA_W/8-aligned.
- size  in  SIZE_W  words per frame; 0 to 2^MEM_ADDR_W.
- frames  in  FRAMES_W  number of frames; 0 is treated as 1.
- burst_len  in  8  maximum beats-1 per burst.
- ping_pong  in  1  1 = two banks with fill/drain overlap; 0 = single bank.

Behaviour:
- Reset values: done=0, err=0, in_ready=0, databus_valid=0, databus_len=0, databus_addr=0, databus_wdata=0. All counters clear; FSM in IDLE.
- run: accepted only in IDLE or DONE; ignored while busy. It latches the configuration, clears done and err, and marks both banks empty.
- Frame f destination: ext_addr + f*size*(DATA_W/8).
- Fill side: in_ready=1 when the fill bank is empty and frames remain to fill. On each in_valid&in_ready the word is written at the fill counter. When the fill counter reaches size, the bank is marked full.
  - ping_pong=1: filling switches to the other bank next cycle.
  - ping_pong=0: in_ready stays low until the drain side releases the bank.
  - A bank that is both being filled and being released in the same cycle is released first, so there is no lost cycle.
- Drain FSM states: IDLE, WAIT_BANK, PREFETCH, BURST, DONE.
  - WAIT_BANK → PREFETCH when the drain bank is full.
  - PREFETCH: one cycle. Issues the RAM read of the first beat (RAM read latency is 1) and computes the burst. Burst beats = min(burst_len+1, words remaining in frame, beats remaining to the next 4 KB boundary). databus_len = beats-1.
  - BURST: databus_valid=1 while data is held in the output register. A one-entry skid register keeps reads one word ahead, so back-to-back beats are sustained when databus_ready is held high.
  - Final beat accepted:
    - If the frame has words left → PREFETCH.
    - Otherwise release the bank and go to WAIT_BANK, or to DONE after the last frame.
  - databus_addr advances by beats*(DATA_W/8) per burst.
- done: rises one cycle after the last beat handshake. size=0: no bus or stream traffic, and done rises two cycles after run.
- err: set if databus_last=1 on a non-final accepted beat, or 0 on the final one. The beat counter, not databus_last, ends the burst.
- rst_n asserted mid-operation aborts immediately with no flush; RAM contents are undefined.

Optional Feature:
- Macro: VWRITE_PP_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0], cleared by run, incrementing every cycle databus_valid=1 and databus_ready=0. It saturates at all ones.
- Undefined: the port is absent and no counter logic exists.

Decomposition:
- Package vwrite_pp_pkg holds:
  - FSM state encoding;
  - the 4 KB boundary constant (12 address bits);
  - the BYTES_PER_WORD = DATA_W/8 localparam function.
- One sub-module, vwrite_burst_gen: given the current address, words remaining and burst_len, it returns beats and the next address; purely combinational plus a registered output.
- The RAM reuses iob_2p_ram with ADDR_W = MEM_ADDR_W+1; the bank-select bit is the MSB.

Test Plan:
- Single bank, ping_pong=0, size=8, frames=1, burst_len=3, ext_addr=0x100, ready always 1 → two bursts: addr 0x100 len 3, then 0x110 len 3. Data equals input order; done one cycle after the 8th beat.
- size=10, burst_len=15, ext_addr=0xFF8 → burst 0xFF8 len 1 (4 KB split), then 0x1000 len 7.
- ping_pong=1, size=4, frames=4, in_valid always 1, databus_ready toggling 1/0 → in_ready stays high during frame 2 fill while frame 1 drains. 16 beats to 0x0..0x3C in order; stall_cnt (if enabled) equals the number of ready=0 cycles with valid high.
- size=0, frames=3 → no databus_valid, in_ready stays 0, done two cycles after run.
- Slave asserts databus_last on beat 2 of a 4-beat burst → burst still 4 beats and err=1 until the next run.
- rst_n pulsed low mid-burst → all outputs reset values next edge; a following run with size=2 completes normally.

Source files
------------

// File: rtl/vwrite_pp_pkg.sv
// Shared constants for the vwrite_pp buffered stream-to-databus writer:
// drain FSM encoding, the 4 KB burst boundary and the bytes-per-word helper.
package vwrite_pp_pkg;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_BANK = 3'd1;
   localparam logic [2:0] S_PREFETCH  = 3'd2;
   localparam logic [2:0] S_BURST     = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   localparam int BOUNDARY_BITS = 12;

   function automatic int bytes_per_word(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/vwrite_pp_if.sv
// Stream input and databus write channel of vwrite_pp. The master modport is
// the writer unit (consumes the stream, masters the databus).
interface vwrite_pp_if #(
   parameter int DATA_W    = 32,
   parameter int IO_ADDR_W = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_data;
   logic                  databus_valid;
   logic                  databus_ready;
   logic [IO_ADDR_W-1:0]  databus_addr;
   logic [DATA_W-1:0]     databus_wdata;
   logic [DATA_W/8-1:0]   databus_wstrb;
   logic [7:0]            databus_len;
   logic                  databus_last;

   modport master (
      input  in_valid, in_data, databus_ready, databus_last,
      output in_ready, databus_valid, databus_addr, databus_wdata, databus_wstrb, databus_len
   );

   modport slave (
      output in_valid, in_data, databus_ready, databus_last,
      input  in_ready, databus_valid, databus_addr, databus_wdata, databus_wstrb, databus_len
   );
endinterface

// File: rtl/iob_2p_ram.sv
// Simple two-port RAM: one synchronous write port, one registered read port
// (read latency 1). Contents are not reset.
module iob_2p_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_en,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [DATA_W-1:0] r_data
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (w_en) r_mem[w_addr] <= w_data;
      if (r_en) r_data <= r_mem[r_addr];
   end
endmodule

// File: rtl/vwrite_burst_gen.sv
// Burst sizing: beats = min(burst_len+1, words left, words to next 4 KB line).
// The chosen burst's start address, len and follow-on address are registered on load.
module vwrite_burst_gen
   import vwrite_pp_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int IO_ADDR_W = 32,
   parameter int SIZE_W    = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic [IO_ADDR_W-1:0] i_addr,
   input  logic [SIZE_W-1:0]    i_rem,
   input  logic [7:0]           i_burst_len,
   output logic [8:0]           o_beats,
   output logic [IO_ADDR_W-1:0] o_addr,
   output logic [7:0]           o_len,
   output logic [IO_ADDR_W-1:0] o_next_addr
);
   localparam int BPW_LOG = $clog2(bytes_per_word(DATA_W));

   logic [BOUNDARY_BITS:0] w_bnd_bytes, w_bnd_words;
   logic [8:0]             w_max, w_rem, w_bnd, w_beats;

   assign w_bnd_bytes = (BOUNDARY_BITS+1)'(1 << BOUNDARY_BITS) - {1'b0, i_addr[BOUNDARY_BITS-1:0]};
   assign w_bnd_words = w_bnd_bytes >> BPW_LOG;

   // Every term is clipped to 256 so the min is done in 9 bits
   assign w_max = {1'b0, i_burst_len} + 9'd1;
   assign w_rem = (i_rem > SIZE_W'(256)) ? 9'd256 : i_rem[8:0];
   assign w_bnd = (w_bnd_words > (BOUNDARY_BITS+1)'(256)) ? 9'd256 : w_bnd_words[8:0];

   always_comb begin
      w_beats = w_max;
      if (w_rem < w_beats) w_beats = w_rem;
      if (w_bnd < w_beats) w_beats = w_bnd;
   end

   assign o_beats = w_beats;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_addr      <= '0;
         o_len       <= '0;
         o_next_addr <= '0;
      end else if (i_load) begin
         o_addr      <= i_addr;
         o_len       <= 8'(w_beats - 9'd1);
         o_next_addr <= i_addr + (IO_ADDR_W'(w_beats) << BPW_LOG);
      end
   end
endmodule

// File: rtl/vwrite_pp.sv
// vwrite_pp: buffers a valid/ready word stream in one or two (ping-pong) RAM
// banks and drains it as 4 KB-safe bursts. `define VWRITE_PP_STALL_CNT_EN adds o_stall_cnt.
module vwrite_pp
   import vwrite_pp_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int IO_ADDR_W  = 32,
   parameter int MEM_ADDR_W = 10,
   parameter int SIZE_W     = 11,
   parameter int FRAMES_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_run,
   output logic                 o_done,
   output logic                 o_err,
   input  logic [IO_ADDR_W-1:0] i_ext_addr,
   input  logic [SIZE_W-1:0]    i_size,
   input  logic [FRAMES_W-1:0]  i_frames,
   input  logic [7:0]           i_burst_len,
   input  logic                 i_ping_pong,
`ifdef VWRITE_PP_STALL_CNT_EN
   output logic [31:0]          o_stall_cnt,
`endif
   vwrite_pp_if.master          bus
);
   logic [2:0]            r_state;
   logic [SIZE_W-1:0]     r_size, r_rem;
   logic [FRAMES_W-1:0]   r_frames;
   logic [7:0]            r_burst_len;
   logic                  r_pp, r_err;
   logic [1:0]            r_full;
   logic                  r_fill_bank, r_drain_bank;
   logic [MEM_ADDR_W-1:0] r_fill_cnt, r_rd_ptr;
   logic [FRAMES_W:0]     r_fill_frame, r_drain_frame;
   logic [IO_ADDR_W-1:0]  r_addr;
   logic [8:0]            r_rd_left, r_beats_left;
   logic                  r_rd_pend, r_out_vld, r_skid_vld;
   logic [DATA_W-1:0]     r_out_data, r_skid_data;

   logic                  w_busy, w_start, w_wr, w_wr_last, w_pop, w_last_beat, w_rd_issue;
   logic [1:0]            w_set, w_rel, w_occ;
   logic [DATA_W-1:0]     w_rd_data;
   logic [8:0]            w_beats;
   logic [IO_ADDR_W-1:0]  w_next_addr;

   assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_start = i_run && !w_busy;

   assign bus.in_ready = w_busy && (r_size != '0) && (r_fill_frame < {1'b0, r_frames})
                         && !r_full[r_fill_bank];
   assign w_wr      = bus.in_valid && bus.in_ready;
   assign w_wr_last = (SIZE_W'(r_fill_cnt) == r_size - 1'b1);
   assign w_set     = (w_wr && w_wr_last) ? (2'b01 << r_fill_bank) : 2'b00;

   assign w_pop       = r_out_vld && bus.databus_ready;
   assign w_last_beat = (r_beats_left == 9'd1);
   assign w_rel       = (r_state == S_BURST && w_pop && w_last_beat && r_rem == '0)
                        ? (2'b01 << r_drain_bank) : 2'b00;

   // Words held or in flight once this cycle's pop retires; keep at most two
   assign w_occ      = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_pend} - {1'b0, w_pop};
   assign w_rd_issue = (r_state == S_PREFETCH) ||
                       (r_state == S_BURST && r_rd_left != '0 && w_occ <= 2'd1);

   iob_2p_ram #(.DATA_W(DATA_W), .ADDR_W(MEM_ADDR_W+1)) u_ram (
      .clk    (clk),
      .w_en   (w_wr),
      .w_addr ({r_fill_bank, r_fill_cnt}),
      .w_data (bus.in_data),
      .r_en   (w_rd_issue),
      .r_addr ({r_drain_bank, r_rd_ptr}),
      .r_data (w_rd_data)
   );

   vwrite_burst_gen #(.DATA_W(DATA_W), .IO_ADDR_W(IO_ADDR_W), .SIZE_W(SIZE_W)) u_bgen (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (r_state == S_PREFETCH),
      .i_addr      (r_addr),
      .i_rem       (r_rem),
      .i_burst_len (r_burst_len),
      .o_beats     (w_beats),
      .o_addr      (bus.databus_addr),
      .o_len       (bus.databus_len),
      .o_next_addr (w_next_addr)
   );

   // Fill side; release is applied before the new full mark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= '0; r_fill_bank <= 1'b0; r_fill_cnt <= '0; r_fill_frame <= '0;
      end else if (w_start) begin
         r_full <= '0; r_fill_bank <= 1'b0; r_fill_cnt <= '0; r_fill_frame <= '0;
      end else begin
         r_full <= (r_full & ~w_rel) | w_set;
         if (w_wr) begin
            if (w_wr_last) begin
               r_fill_cnt   <= '0;
               r_fill_bank  <= r_fill_bank ^ r_pp;
               r_fill_frame <= r_fill_frame + 1'b1;
            end else begin
               r_fill_cnt <= r_fill_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE; r_size <= '0; r_frames <= '0; r_burst_len <= '0; r_pp <= 1'b0;
         r_err <= 1'b0; r_drain_bank <= 1'b0; r_drain_frame <= '0; r_rd_ptr <= '0;
         r_rem <= '0; r_addr <= '0; r_rd_left <= '0; r_beats_left <= '0;
      end else if (w_start) begin
         r_state     <= S_WAIT_BANK;
         r_size      <= i_size;
         r_frames    <= (i_frames == '0) ? FRAMES_W'(1) : i_frames;
         r_burst_len <= i_burst_len;
         r_pp        <= i_ping_pong;
         r_err       <= 1'b0;
         r_drain_bank <= 1'b0; r_drain_frame <= '0; r_rd_ptr <= '0;
         r_rem       <= i_size;
         r_addr      <= i_ext_addr;
         r_rd_left   <= '0; r_beats_left <= '0;
      end else begin
         if (w_pop && (bus.databus_last != w_last_beat)) r_err <= 1'b1;
         if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
         case (r_state)
            S_WAIT_BANK:
               if (r_size == '0)               r_state <= S_DONE;
               else if (r_full[r_drain_bank])  r_state <= S_PREFETCH;
            S_PREFETCH: begin
               r_rem        <= r_rem - SIZE_W'(w_beats);
               r_rd_left    <= w_beats - 9'd1;
               r_beats_left <= w_beats;
               r_state      <= S_BURST;
            end
            S_BURST: begin
               if (w_rd_issue) r_rd_left <= r_rd_left - 9'd1;
               if (w_pop) begin
                  r_beats_left <= r_beats_left - 9'd1;
                  if (w_last_beat) begin
                     r_addr <= w_next_addr;
                     if (r_rem != '0) begin
                        r_state <= S_PREFETCH;
                     end else begin
                        r_drain_bank  <= r_drain_bank ^ r_pp;
                        r_drain_frame <= r_drain_frame + 1'b1;
                        r_rd_ptr      <= '0;
                        r_rem         <= r_size;
                        r_state       <= (r_drain_frame + 1'b1 == {1'b0, r_frames}) ? S_DONE : S_WAIT_BANK;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output register plus one-entry skid keeps the RAM read one word ahead
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_pend <= 1'b0; r_out_vld <= 1'b0; r_skid_vld <= 1'b0;
         r_out_data <= '0; r_skid_data <= '0;
      end else if (w_start) begin
         r_rd_pend <= 1'b0; r_out_vld <= 1'b0; r_skid_vld <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_issue;
         if (!r_out_vld || w_pop) begin
            if (r_skid_vld) begin
               r_out_vld  <= 1'b1;
               r_out_data <= r_skid_data;
               r_skid_vld <= r_rd_pend;
               if (r_rd_pend) r_skid_data <= w_rd_data;
            end else begin
               r_out_vld <= r_rd_pend;
               if (r_rd_pend) r_out_data <= w_rd_data;
            end
         end else if (r_rd_pend) begin
            r_skid_vld  <= 1'b1;
            r_skid_data <= w_rd_data;
         end
      end
   end

`ifdef VWRITE_PP_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                           o_stall_cnt <= '0;
      else if (w_start)                                     o_stall_cnt <= '0;
      else if (r_out_vld && !bus.databus_ready && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
   end
`endif

   assign bus.databus_valid = r_out_vld;
   assign bus.databus_wdata = r_out_data;
   assign bus.databus_wstrb = '1;
   assign o_done            = (r_state == S_DONE);
   assign o_err             = r_err;
endmodule

// File: tb/tb_vwrite_pp.sv
// Directed bench for vwrite_pp: burst split, 4 KB split, ping-pong overlap,
// size=0, databus_last error and mid-burst reset.
module tb_vwrite_pp;
   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, pp = 1'b0;
   logic        done, err;
   logic [31:0] ext_addr = '0;
   logic [10:0] size = '0;
   logic [7:0]  frames = '0, burst_len = '0;
`ifdef VWRITE_PP_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_checks = 0, n_fail = 0, cyc = 0;
   int last_hs = 0, tot_beats = 0, bidx = 0, exp_stall = 0, overlap = 0;
   logic last_bad = 1'b0;
   logic [31:0] q_addr[$], q_data[$];
   logic [7:0]  q_len[$];

   vwrite_pp_if #(.DATA_W(32), .IO_ADDR_W(32)) bus();

   vwrite_pp dut (
      .clk(clk), .rst_n(rst_n), .i_run(run), .o_done(done), .o_err(err),
      .i_ext_addr(ext_addr), .i_size(size), .i_frames(frames),
      .i_burst_len(burst_len), .i_ping_pong(pp),
`ifdef VWRITE_PP_STALL_CNT_EN
      .o_stall_cnt(stall_cnt),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.databus_valid && !bus.databus_ready) exp_stall++;
         if (bus.in_ready && bus.databus_valid) overlap++;
         if (bus.databus_valid && bus.databus_ready) begin
            q_addr.push_back(bus.databus_addr);
            q_len.push_back(bus.databus_len);
            q_data.push_back(bus.databus_wdata);
            last_hs = cyc;
            tot_beats++;
            if (bidx == int'(bus.databus_len)) bidx = 0; else bidx++;
         end
      end
   end

   // Slave side databus_last: correct, or deliberately on the 2nd beat only
   always @(posedge clk) begin
      #1;
      bus.databus_last = last_bad ? (tot_beats == 1) : (bidx == int'(bus.databus_len));
   end

   task automatic clear_mon();
      q_addr.delete(); q_len.delete(); q_data.delete();
      tot_beats = 0; bidx = 0; exp_stall = 0; overlap = 0;
   endtask

   task automatic start(input logic [31:0] a, input logic [10:0] s, input logic [7:0] f,
                        input logic [7:0] bl, input logic p);
      clear_mon();
      ext_addr = a; size = s; frames = f; burst_len = bl; pp = p;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
   endtask

   task automatic feed(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         int w = 0;
         bus.in_valid = 1'b1; bus.in_data = base + k;
         @(negedge clk);
         while (!bus.in_ready && w < 2000) begin @(negedge clk); w++; end
         if (w >= 2000) begin
            n_checks++; n_fail++;
            $display("FAIL feed_timeout: word %0d in_ready=0 required 1", k);
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done) begin dc = cyc; break; end
      end
      n_checks++;
      if (dc < 0) begin n_fail++; $display("FAIL done_timeout: done=0 required 1"); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.databus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.databus_valid); end
      n_checks++; if (bus.databus_len !== 8'h0) begin n_fail++; $display("FAIL rst_len: got %h want 0", bus.databus_len); end
      n_checks++; if (bus.databus_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.databus_addr); end
      n_checks++; if (bus.databus_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", bus.databus_wdata); end
      n_checks++; if (bus.databus_wstrb !== 4'hF) begin n_fail++; $display("FAIL wstrb: got %h want f", bus.databus_wstrb); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single_bank();
      int dc;
      bus.databus_ready = 1'b1;
      start(32'h100, 11'd8, 8'd1, 8'd3, 1'b0);
      feed(8, 32'h1000);
      wait_done(dc);
      n_checks++; if (q_data.size() != 8) begin n_fail++; $display("FAIL sb_beats: got %0d want 8", q_data.size()); end
      else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (q_data[i] !== 32'h1000 + i) begin n_fail++; $display("FAIL sb_data[%0d]: got %h want %h", i, q_data[i], 32'h1000 + i); end
         end
         n_checks++; if (q_addr[0] !== 32'h100 || q_len[0] !== 8'd3) begin n_fail++; $display("FAIL sb_burst0: got %h/%0d want 100/3", q_addr[0], q_len[0]); end
         n_checks++; if (q_addr[3] !== 32'h100) begin n_fail++; $display("FAIL sb_addr_held: got %h want 100", q_addr[3]); end
         n_checks++; if (q_addr[4] !== 32'h110 || q_len[4] !== 8'd3) begin n_fail++; $display("FAIL sb_burst1: got %h/%0d want 110/3", q_addr[4], q_len[4]); end
      end
      n_checks++; if (dc != last_hs + 1) begin n_fail++; $display("FAIL sb_done_lat: got cyc %0d want %0d", dc, last_hs + 1); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", err); end
   endtask

   task automatic test_4k_split();
      int dc;
      bus.databus_ready = 1'b1;
      start(32'hFF8, 11'd10, 8'd1, 8'd15, 1'b0);
      feed(10, 32'h3000);
      wait_done(dc);
      n_checks++; if (q_data.size() != 10) begin n_fail++; $display("FAIL 4k_beats: got %0d want 10", q_data.size()); end
      else begin
         n_checks++; if (q_addr[0] !== 32'hFF8 || q_len[0] !== 8'd1) begin n_fail++; $display("FAIL 4k_burst0: got %h/%0d want ff8/1", q_addr[0], q_len[0]); end
         n_checks++; if (q_addr[2] !== 32'h1000 || q_len[2] !== 8'd7) begin n_fail++; $display("FAIL 4k_burst1: got %h/%0d want 1000/7", q_addr[2], q_len[2]); end
         n_checks++; if (q_data[9] !== 32'h3009) begin n_fail++; $display("FAIL 4k_data9: got %h want 3009", q_data[9]); end
      end
   endtask

   task automatic test_ping_pong();
      int dc;
      bus.databus_ready = 1'b1;
      start(32'h0, 11'd4, 8'd4, 8'd3, 1'b1);
      fork
         feed(16, 32'h2000);
         begin
            for (int k = 0; k < 3000 && !done; k++) begin
               @(posedge clk); #1;
               bus.databus_ready = ~bus.databus_ready;
            end
         end
      join
      bus.databus_ready = 1'b1;
      wait_done(dc);
      n_checks++; if (q_data.size() != 16) begin n_fail++; $display("FAIL pp_beats: got %0d want 16", q_data.size()); end
      else begin
         for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (q_data[i] !== 32'h2000 + i || q_addr[i] !== 32'((i / 4) * 16) || q_len[i] !== 8'd3) begin
               n_fail++;
               $display("FAIL pp_beat[%0d]: got %h@%h/%0d want %h@%h/3", i, q_data[i], q_addr[i], q_len[i], 32'h2000 + i, (i / 4) * 16);
            end
         end
      end
      n_checks++; if (overlap == 0) begin n_fail++; $display("FAIL pp_overlap: got %0d cycles want >0", overlap); end
`ifdef VWRITE_PP_STALL_CNT_EN
      n_checks++; if (stall_cnt !== 32'(exp_stall)) begin n_fail++; $display("FAIL pp_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
`endif
   endtask

   task automatic test_size_zero();
      bus.databus_ready = 1'b1;
      start(32'h400, 11'd0, 8'd3, 8'd3, 1'b0);
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sz0_c1: done=%b in_ready=%b want 0 0", done, bus.in_ready); end
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sz0_done: got %b want 1", done); end
      n_checks++; if (q_data.size() != 0 || bus.databus_valid !== 1'b0) begin n_fail++; $display("FAIL sz0_traffic: got %0d beats want 0", q_data.size()); end
   endtask

   task automatic test_last_err();
      int dc;
      bus.databus_ready = 1'b1;
      last_bad = 1'b1;
      start(32'h200, 11'd4, 8'd1, 8'd3, 1'b0);
      feed(4, 32'h4000);
      wait_done(dc);
      n_checks++; if (q_data.size() != 4 || q_len[0] !== 8'd3) begin n_fail++; $display("FAIL le_beats: got %0d want 4", q_data.size()); end
      repeat (3) @(negedge clk);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL le_err: got %b want 1", err); end
      last_bad = 1'b0;
      start(32'h300, 11'd1, 8'd1, 8'd0, 1'b0);
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL le_err_clr: got %b want 0", err); end
      @(posedge clk); #1;
      feed(1, 32'h4100);
      wait_done(dc);
      n_checks++; if (err !== 1'b0 || q_data.size() != 1) begin n_fail++; $display("FAIL le_clean: err=%b beats=%0d want 0 1", err, q_data.size()); end
   endtask

   task automatic test_rst_mid();
      int dc, w;
      bus.databus_ready = 1'b0;
      start(32'h80, 11'd8, 8'd1, 8'd3, 1'b0);
      feed(8, 32'h6000);
      w = 0;
      while (!bus.databus_valid && w < 200) begin @(negedge clk); w++; end
      n_checks++; if (!bus.databus_valid) begin n_fail++; $display("FAIL rm_valid: got 0 want 1"); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.databus_valid !== 1'b0 || bus.databus_addr !== 32'h0 || bus.databus_len !== 8'h0 ||
          bus.databus_wdata !== 32'h0 || done !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_outputs: valid=%b addr=%h len=%h wdata=%h done=%b err=%b rdy=%b want all 0",
                  bus.databus_valid, bus.databus_addr, bus.databus_len, bus.databus_wdata, done, err, bus.in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.databus_ready = 1'b1;
      start(32'h40, 11'd2, 8'd1, 8'd3, 1'b0);
      feed(2, 32'h5000);
      wait_done(dc);
      n_checks++;
      if (q_data.size() != 2) begin n_fail++; $display("FAIL rm_beats: got %0d want 2", q_data.size()); end
      else if (q_addr[0] !== 32'h40 || q_len[0] !== 8'd1 || q_data[0] !== 32'h5000 || q_data[1] !== 32'h5001) begin
         n_fail++;
         $display("FAIL rm_burst: got %h/%0d %h %h want 40/1 5000 5001", q_addr[0], q_len[0], q_data[0], q_data[1]);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0;
      bus.databus_ready = 1'b1; bus.databus_last = 1'b0;
      test_reset();
      test_single_bank();
      test_4k_split();
      test_ping_pong();
      test_size_zero();
      test_last_err();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
